// File: rtl/rvfi_retire_serializer.sv
// Reorders retirements from NRET RVFI channels into a single rvfi_order-sequenced
// valid/ready stream, with sticky flags for window overflow and duplicate orders.
module rvfi_retire_serializer #(
   parameter int NRET  = 2,
   parameter int XLEN  = 32,
   parameter int DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NRET-1:0]           rvfi_valid,
   input  logic [NRET*8-1:0]         rvfi_order,
   input  logic [NRET*32-1:0]        rvfi_insn,
   input  logic [NRET*XLEN-1:0]      rvfi_pre_pc,
   input  logic [NRET-1:0]           rvfi_trap,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [7:0]                out_order,
   output logic [31:0]               out_insn,
   output logic [XLEN-1:0]           out_pc,
   output logic                      out_trap,
   output logic [$clog2(DEPTH):0]    occupancy,
   output logic                      err_overflow,
   output logic                      err_dup
);

   localparam int         IW      = $clog2(DEPTH);
   localparam int         OW      = IW + 1;
   localparam logic [7:0] DEPTH_W = 8'(DEPTH);

   logic [DEPTH-1:0]             vld_q, vld_d;
   logic [DEPTH-1:0][7:0]        order_q;
   logic [DEPTH-1:0][31:0]       insn_q;
   logic [DEPTH-1:0][XLEN-1:0]   pc_q;
   logic [DEPTH-1:0]             trap_q;
   logic [7:0]                   exp_q, exp_d;
   logic [OW-1:0]                occ_q, occ_d;
   logic                         err_ovf_q, err_dup_q;

   logic [IW-1:0]                exp_idx;
   logic                         pop;
   logic [NRET-1:0]              wr;
   logic [NRET-1:0][IW-1:0]      widx;
   logic [DEPTH-1:0]             claim;
   logic                         ovf_hit, dup_hit;

   assign exp_idx = exp_q[IW-1:0];
   assign pop     = vld_q[exp_idx] & out_ready;

   // Window check uses the pre-increment exp; lower channels claim slots first.
   // NOTE: blocking assignments here so later channels see earlier claims within the same evaluation.
   always_comb begin
      wr      = '0;
      widx    = '0;
      claim   = '0;
      ovf_hit = 1'b0;
      dup_hit = 1'b0;
      for (int c = 0; c < NRET; c++) begin
         widx[c] = rvfi_order[c*8 +: IW];
         if (rvfi_valid[c]) begin
            if (8'(rvfi_order[c*8 +: 8] - exp_q) >= DEPTH_W) begin
               ovf_hit = 1'b1;
            end else if (vld_q[widx[c]] || claim[widx[c]]) begin
               dup_hit = 1'b1;
            end else begin
               wr[c]           = 1'b1;
               claim[widx[c]]  = 1'b1;
            end
         end
      end
   end

   always_comb begin
      vld_d = vld_q | claim;
      if (pop) begin
         vld_d[exp_idx] = 1'b0;
      end
      occ_d = '0;
      for (int i = 0; i < DEPTH; i++) begin
         occ_d = occ_d + OW'(vld_d[i]);
      end
      exp_d = exp_q + {7'd0, pop};
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (reset) begin
         vld_q     <= '0;
         exp_q     <= '0;
         occ_q     <= '0;
         err_ovf_q <= 1'b0;
         err_dup_q <= 1'b0;
      end else begin
         vld_q     <= vld_d;
         exp_q     <= exp_d;
         occ_q     <= occ_d;
         err_ovf_q <= err_ovf_q | ovf_hit;
         err_dup_q <= err_dup_q | dup_hit;
      end
   end

   // NOTE: slot payload is not reset; it is only ever observed behind its vld bit.
   always_ff @(posedge clk) begin
      for (int c = 0; c < NRET; c++) begin
         if (wr[c]) begin
            order_q[widx[c]] <= rvfi_order[c*8 +: 8];
            insn_q[widx[c]]  <= rvfi_insn[c*32 +: 32];
            pc_q[widx[c]]    <= rvfi_pre_pc[c*XLEN +: XLEN];
            trap_q[widx[c]]  <= rvfi_trap[c];
         end
      end
   end

   assign out_valid    = vld_q[exp_idx];
   assign out_order    = out_valid ? order_q[exp_idx] : '0;
   assign out_insn     = out_valid ? insn_q[exp_idx]  : '0;
   assign out_pc       = out_valid ? pc_q[exp_idx]    : '0;
   assign out_trap     = out_valid & trap_q[exp_idx];
   assign occupancy    = occ_q;
   assign err_overflow = err_ovf_q;
   assign err_dup      = err_dup_q;

endmodule
